// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VESA-style raster timing (sync, active, coordinates, strobes)
// Latency: hsync/vsync/active follow the counters, delayed by PIPE_DLY pixel ticks; strobes same cycle as tick
// Backpressure: none; en_i low freezes divider, counters and delay line
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int DIV      = 4,
  parameter int PIPE_DLY = 0,
  parameter int CW       = 10
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  output logic          pix_en_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          disp_active,
  output logic [CW-1:0] xcol_o,
  output logic [CW-1:0] yrow_o,
  output logic          line_start_o,
  output logic          frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW      = PIPE_DLY + 1;
  localparam logic HP    = (H_POL != 0);
  localparam logic VP    = (V_POL != 0);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] X_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] Y_LAST   = CW'(V_TOTAL - 1);

  logic [DW-1:0] r_div_cnt;
  logic [CW-1:0] r_xcol;
  logic [CW-1:0] r_yrow;
  logic [PW-1:0] r_hs_pipe;
  logic [PW-1:0] r_vs_pipe;
  logic [PW-1:0] r_act_pipe;

  logic          w_div_last;
  logic          w_x_wrap;
  logic [CW-1:0] w_x_next;
  logic [CW-1:0] w_y_next;
  logic          w_act_nxt;
  logic          w_hs_nxt;
  logic          w_vs_nxt;

  // Reset gates the tick so nothing strobes while held in reset, even with DIV=1.
  assign w_div_last = (r_div_cnt == DIV_LAST);
  assign pix_en_o   = rst_ni & en_i & w_div_last;

  // Counter successors; the registered decode is taken from these so that with
  // PIPE_DLY=0 the sync/active outputs line up with the coordinates they describe.
  assign w_x_wrap = (r_xcol == X_LAST);
  assign w_x_next = w_x_wrap ? '0 : r_xcol + 1'b1;
  assign w_y_next = w_x_wrap ? ((r_yrow == Y_LAST) ? '0 : r_yrow + 1'b1) : r_yrow;

  assign w_act_nxt = (int'(w_x_next) < H_ACTIVE) && (int'(w_y_next) < V_ACTIVE);
  assign w_hs_nxt  = ((int'(w_x_next) >= H_ACTIVE + H_FP) &&
                      (int'(w_x_next) <  H_ACTIVE + H_FP + H_SYNC)) ? HP : ~HP;
  assign w_vs_nxt  = ((int'(w_y_next) >= V_ACTIVE + V_FP) &&
                      (int'(w_y_next) <  V_ACTIVE + V_FP + V_SYNC)) ? VP : ~VP;

  // Pixel-tick divider: counts enabled clocks, wraps on the tick.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_div_cnt <= '0;
    end else if (en_i) begin
      r_div_cnt <= w_div_last ? '0 : r_div_cnt + 1'b1;
    end
  end

  // Raster counters advance once per pixel tick; y steps on the x wrap.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_xcol <= '0;
      r_yrow <= '0;
    end else if (pix_en_o) begin
      r_xcol <= w_x_next;
      r_yrow <= w_y_next;
    end
  end

  // Delay line for sync/active: stage 0 holds the current decode, stage k the decode k ticks ago.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_hs_pipe  <= {PW{~HP}};
      r_vs_pipe  <= {PW{~VP}};
      r_act_pipe <= '0;
    end else if (pix_en_o) begin
      r_hs_pipe  <= (r_hs_pipe  << 1) | PW'(w_hs_nxt);
      r_vs_pipe  <= (r_vs_pipe  << 1) | PW'(w_vs_nxt);
      r_act_pipe <= (r_act_pipe << 1) | PW'(w_act_nxt);
    end
  end

  assign hsync_o     = r_hs_pipe[PIPE_DLY];
  assign vsync_o     = r_vs_pipe[PIPE_DLY];
  assign disp_active = r_act_pipe[PIPE_DLY];
  assign xcol_o      = r_xcol;
  assign yrow_o      = r_yrow;

  // Strobes are undelayed and only ever one clk wide because they ride on the tick.
  assign line_start_o  = pix_en_o & (r_xcol == '0);
  assign frame_start_o = line_start_o & (r_yrow == '0);

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA controller and its external 25 MHz divider.
- Runs on the single system clock and generates its own pixel-tick clock enable; no derived clock.
- Produces hsync/vsync/display-active, pixel coordinates, and frame/line start strobes for any VESA-style mode.
- Provides programmable sync polarity and a pixel-tick pipeline delay, so sync outputs align with downstream pixel-data pipelines.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixel ticks)
- H_SYNC, 96, hsync width (pixel ticks)
- H_BP, 48, horizontal back porch (pixel ticks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync asserted level (0 = active-low)
- V_POL, 0, vsync asserted level
- DIV, 4, clk_i cycles per pixel tick; must be >=1
- PIPE_DLY, 0, pixel-tick delay applied to hsync_o/vsync_o/disp_active; range 0..7
- CW, 10, coordinate counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  synchronous reset, active-low
- en_i  in  1  run enable; low freezes all timing state
- pix_en_o  out  1  one-clk pixel-tick strobe
- hsync_o  out  1  horizontal sync, polarity per H_POL
- vsync_o  out  1  vertical sync, polarity per V_POL
- disp_active  out  1  high inside the visible region
- xcol_o  out  CW  horizontal counter
- yrow_o  out  CW  vertical counter
- line_start_o  out  1  one-clk strobe at x=0
- frame_start_o  out  1  one-clk strobe at x=0, y=0

Behaviour:
- Reset: rst_ni sampled low at a clk_i edge clears the divider, xcol_o, and yrow_o to 0 and drives pix_en_o, disp_active, and both strobes to 0.
  - hsync_o=~H_POL, vsync_o=~V_POL.
  - Every delay-line stage is loaded with the deasserted values.
  - Reset overrides en_i. Reset mid-frame takes effect on the next edge.
- Divider: div_cnt counts 0..DIV-1 while en_i=1. pix_en_o=1 when div_cnt==DIV-1 and en_i=1, then div_cnt wraps to 0. With DIV=1, pix_en_o=en_i.
- en_i=0: div_cnt, counters, and delay line hold; pix_en_o=0; outputs hold their last values.
- Counters advance only on pix_en_o.
  - H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
  - xcol_o increments and wraps from H_TOTAL-1 to 0.
  - On that wrap, yrow_o increments and wraps from V_TOTAL-1 to 0.
- Decode (combinational from the counters):
  - act = (x<H_ACTIVE)&&(y<V_ACTIVE)
  - hs = H_POL when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, else ~H_POL
  - vs = V_POL when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, else ~V_POL. vs is line-based and changes at the x wrap.
- Delay: with PIPE_DLY=0, outputs equal the decode. With PIPE_DLY=k, outputs equal the decode from k pixel ticks earlier, via a k-stage shift register clocked by pix_en_o. xcol_o and yrow_o are never delayed.
- line_start_o = pix_en_o && x==0. frame_start_o = pix_en_o && x==0 && y==0.
  - Both are undelayed and last exactly one clk_i cycle.
  - The first pixel tick after reset strobes both.
- Outputs are registered except pix_en_o and the strobes, which are decoded from registered state.

Test Plan:
- Reset: defaults, hold rst_ni=0 for 3 clk with en_i=1 -> xcol=yrow=0, hsync_o=vsync_o=1, disp_active=0, pix_en_o=0.
- Divider: defaults, release reset with en_i=1 -> pix_en_o high on clk 4, 8, 12...; frame_start_o and line_start_o high on clk 4 only; xcol_o=1 after clk 4.
- Hsync/active: defaults, line 0 -> disp_active=1 for x 0..639; hsync_o=0 for x 656..751 (96 ticks = 384 clk); line period 800 ticks.
- Frame wrap: defaults, run 800*525 ticks -> vsync_o=0 only on lines 490..491; disp_active=0 for y>=480; counters return to (0,0) with a single frame_start_o.
- Freeze: defaults, drop en_i for 20 clk at xcol=100 -> xcol holds at 100, no pix_en_o, div_cnt holds; on resume, the next tick arrives after the remaining divider count.
- Small mode:
  - Config: H 8/2/2/2, V 4/1/1/1, DIV=1, H_POL=1, PIPE_DLY=2.
  - Sync timing: hsync_o=1 while xcol_o=12,13; frame period 14*7=98 clk.
  - Mid-frame reset: rst_ni=0 at xcol=5 -> xcol=0 and hsync_o=0 on the next clk.
